// File: rtl/score_pkg.sv
// score_pkg
//  Shared types and constants for the score/lives text RAM feeder.
//  state_t      : sequencer states of score_tracker
//  ASCII_ZERO   : offset turning a decimal digit into its ASCII character
//  LABEL_ROM    : the static "Score:" and "Lives:" labels as {addr, data} pairs,
//                 each terminated by a 00h byte
package score_pkg;

    typedef enum logic [2:0] {
        LABELS,
        IDLE,
        CONVERT,
        WR_H,
        WR_T,
        WR_O,
        WR_L
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam int         LABEL_COUNT = 14;

    localparam logic [15:0] LABEL_ROM [LABEL_COUNT] = '{
        16'h0053, 16'h0163, 16'h026F, 16'h0372, 16'h0465, 16'h053A, 16'h0600,
        16'h194C, 16'h1A69, 16'h1B76, 16'h1C65, 16'h1D73, 16'h1E3A, 16'h1F00
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//  Sequential double-dabble converter: one shift per clock, ten shifts for a
//  10-bit input, done pulses for one cycle alongside the final shift.
//  A start while busy reloads the operand and restarts from scratch.
//  Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               load bin and begin a conversion
//   bin[9:0]            binary operand (0..999 expected)
//   busy                conversion in progress
//   done                one-cycle pulse, digits valid from this cycle on
//   hundreds/tens/ones  BCD result, held until the next start
module bin2bcd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [21:0] work_q, work_d, work_adj;
    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // work holds {hundreds, tens, ones, remaining binary}; the whole word
    // shifts left so the MSB of the binary part walks into the ones digit.
    always_comb begin
        work_adj = {add3(work_q[21:18]), add3(work_q[17:14]), add3(work_q[13:10]), work_q[9:0]};
        work_d   = work_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            work_d  = {12'd0, bin};
            count_d = 4'd0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            work_d  = work_adj << 1;
            count_d = count_q + 4'd1;
            if (count_q == 4'd9) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            work_q  <= work_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hundreds = work_q[21:18];
    assign tens     = work_q[17:14];
    assign ones     = work_q[13:10];

endmodule

// File: rtl/score_tracker.sv
// score_tracker
//  Accumulates game events into a saturating score and a lives counter,
//  derives game_over, and keeps the on-screen text RAM up to date: labels
//  after reset/new game, then three score digits and one lives digit after
//  every counter change.
//  Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   new_game            restart pulse, same effect as Reset
//   pellet/power/ghost  scoring event pulses (summed when coincident)
//   pacman_caught       lose-a-life pulse
//   score, lives        current counters
//   game_over           high while lives is zero
//   busy                sequencer is not idle
//   ram_we/addr/data    text RAM write port, one byte per strobe
module score_tracker
    import score_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int PELLET_PTS  = 1,
    parameter int POWER_PTS   = 5,
    parameter int GHOST_PTS   = 20,
    parameter int SCORE_MAX   = 999,
    parameter int ADDR_SCORE  = 7,
    parameter int ADDR_LIVES  = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       new_game,
    input  logic       pellet_eaten,
    input  logic       power_eaten,
    input  logic       ghost_eaten,
    input  logic       pacman_caught,
    output logic [9:0] score,
    output logic [7:0] lives,
    output logic       game_over,
    output logic       busy,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data
);

    state_t      state_q, state_d;
    logic [3:0]  label_idx_q, label_idx_d;
    logic [9:0]  score_q, score_d;
    logic [7:0]  lives_q, lives_d;
    logic [7:0]  lives_snap_q, lives_snap_d;
    logic        game_over_q, game_over_d;
    logic        dirty_q, dirty_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;

    logic        restart;
    logic [10:0] event_pts;
    logic [10:0] score_sum;
    logic [15:0] label_entry;
    logic        bcd_start, bcd_busy, bcd_done;
    logic [3:0]  bcd_hundreds, bcd_tens, bcd_ones;

    assign restart     = Reset | new_game;
    assign label_entry = LABEL_ROM[label_idx_q];

    bin2bcd_seq u_bin2bcd (
        .clk      (Clk),
        .reset    (restart),
        .start    (bcd_start),
        .bin      (score_q),
        .busy     (bcd_busy),
        .done     (bcd_done),
        .hundreds (bcd_hundreds),
        .tens     (bcd_tens),
        .ones     (bcd_ones)
    );

    // Counter update. The sum is formed one bit wider than the score so the
    // saturation compare sees true overflow past SCORE_MAX.
    always_comb begin
        event_pts = (pellet_eaten ? 11'(PELLET_PTS) : 11'd0)
                  + (power_eaten  ? 11'(POWER_PTS)  : 11'd0)
                  + (ghost_eaten  ? 11'(GHOST_PTS)  : 11'd0);
        score_sum = {1'b0, score_q} + event_pts;
        score_d   = score_q;
        lives_d   = lives_q;
        if (!game_over_q) begin
            if (score_sum > 11'(SCORE_MAX)) begin
                score_d = 10'(SCORE_MAX);
            end else begin
                score_d = score_sum[9:0];
            end
            if (pacman_caught && (lives_q != 8'd0)) begin
                lives_d = lives_q - 8'd1;
            end
        end
        game_over_d = (lives_d == 8'd0);
    end

    // Sequencer. RAM port values are registered, so each write state's byte
    // appears on the port one cycle after the state. Dirty is cleared when a
    // snapshot is taken but re-set by any change in the same cycle, so a late
    // event always triggers another full rewrite.
    always_comb begin
        state_d      = state_q;
        label_idx_d  = label_idx_q;
        lives_snap_d = lives_snap_q;
        dirty_d      = dirty_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        bcd_start    = 1'b0;
        case (state_q)
            LABELS: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = label_entry[15:8];
                ram_data_d  = label_entry[7:0];
                label_idx_d = label_idx_q + 4'd1;
                if (label_idx_q == 4'(LABEL_COUNT - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (dirty_q) begin
                    bcd_start    = 1'b1;
                    lives_snap_d = lives_q;
                    dirty_d      = 1'b0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                if (bcd_done) begin
                    state_d = WR_H;
                end else if (!bcd_busy) begin
                    bcd_start = 1'b1;
                end
            end
            WR_H: begin
                ram_we_d   = 1'b1;
                ram_addr_d = 8'(ADDR_SCORE);
                ram_data_d = ASCII_ZERO + {4'd0, bcd_hundreds};
                state_d    = WR_T;
            end
            WR_T: begin
                ram_we_d   = 1'b1;
                ram_addr_d = 8'(ADDR_SCORE + 1);
                ram_data_d = ASCII_ZERO + {4'd0, bcd_tens};
                state_d    = WR_O;
            end
            WR_O: begin
                ram_we_d   = 1'b1;
                ram_addr_d = 8'(ADDR_SCORE + 2);
                ram_data_d = ASCII_ZERO + {4'd0, bcd_ones};
                state_d    = WR_L;
            end
            WR_L: begin
                ram_we_d   = 1'b1;
                ram_addr_d = 8'(ADDR_LIVES);
                ram_data_d = ASCII_ZERO + lives_snap_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((score_d != score_q) || (lives_d != lives_q)) begin
            dirty_d = 1'b1;
        end
    end

    // new_game is folded into the reset so it aborts any sequence in flight.
    always_ff @(posedge Clk) begin
        if (restart) begin
            state_q      <= LABELS;
            label_idx_q  <= 4'd0;
            score_q      <= 10'd0;
            lives_q      <= 8'(START_LIVES);
            lives_snap_q <= 8'd0;
            game_over_q  <= 1'b0;
            dirty_q      <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 8'd0;
            ram_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            label_idx_q  <= label_idx_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            lives_snap_q <= lives_snap_d;
            game_over_q  <= game_over_d;
            dirty_q      <= dirty_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
        end
    end

    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign busy      = (state_q != IDLE);
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;

endmodule
